// File: rtl/if_stage.sv
// Instruction fetch stage: PC sequencing, imem handshake and IF/ID register.
// One-entry hold buffer absorbs a fetch that lands while decode is stalled.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pcplus4
);

  typedef enum logic [1:0] {
    FETCH,
    HOLD,
    DROP
  } state_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pcplus4;
  } if_id_t;

  localparam logic [31:0] PC_INIT = {RESET_PC[31:2], 2'b00};

  state_t      state;
  state_t      state_nx;
  logic [31:0] pc;
  logic [31:0] pc_nx;
  logic [31:0] drop_addr;
  logic [31:0] drop_addr_nx;
  if_id_t      id_q;
  if_id_t      id_nx;
  if_id_t      hold_q;
  if_id_t      hold_nx;
  logic        valid_q;
  logic        valid_nx;

  logic [31:0] pc_inc;
  logic [31:0] tgt;
  logic        ack;

  assign pc_inc = pc + 32'd4;
  assign tgt    = {redirect_pc[31:2], 2'b00};
  assign ack    = imem_ack & imem_req;

  assign imem_req   = (state != HOLD);
  // DROP keeps presenting the abandoned address until its ack drains.
  assign imem_addr  = (state == DROP) ? drop_addr : pc;
  assign id_valid   = valid_q;
  assign id_instr   = id_q.instr;
  assign id_pcplus4 = id_q.pcplus4;

  always_comb begin
    state_nx     = state;
    pc_nx        = pc;
    drop_addr_nx = drop_addr;
    id_nx        = id_q;
    hold_nx      = hold_q;
    valid_nx     = valid_q;
    unique case (state)
      FETCH: begin
        if (redirect) begin
          pc_nx    = tgt;
          valid_nx = 1'b0;
          if (!ack) begin
            state_nx     = DROP;
            drop_addr_nx = pc;
          end
        end else if (ack) begin
          pc_nx = pc_inc;
          if (!valid_q || !stall) begin
            id_nx    = '{instr: imem_rdata, pcplus4: pc_inc};
            valid_nx = 1'b1;
          end else begin
            hold_nx  = '{instr: imem_rdata, pcplus4: pc_inc};
            state_nx = HOLD;
          end
        end else if (!stall) begin
          valid_nx = 1'b0;
        end
      end
      HOLD: begin
        if (redirect) begin
          pc_nx    = tgt;
          valid_nx = 1'b0;
          state_nx = FETCH;
        end else if (!stall) begin
          id_nx    = hold_q;
          valid_nx = 1'b1;
          state_nx = FETCH;
        end
      end
      DROP: begin
        valid_nx = 1'b0;
        if (redirect) begin
          pc_nx = tgt;
        end
        if (ack) begin
          state_nx = FETCH;
        end
      end
      default: begin
        state_nx = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= FETCH;
      pc        <= PC_INIT;
      drop_addr <= '0;
      id_q      <= '0;
      hold_q    <= '0;
      valid_q   <= 1'b0;
    end else begin
      state     <= state_nx;
      pc        <= pc_nx;
      drop_addr <= drop_addr_nx;
      id_q      <= id_nx;
      hold_q    <= hold_nx;
      valid_q   <= valid_nx;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios then random traffic,
// checked against a queue-based fetch model.
module tb_if_stage;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pcplus4;

  logic        rst2_n;
  logic        req2;
  logic [31:0] addr2;
  logic        v2;
  logic [31:0] instr2;
  logic [31:0] p42;
  logic [31:0] rdata2;

  int passed = 0;
  int total  = 0;

  if_stage dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pcplus4(id_pcplus4)
  );

  assign rdata2 = addr2 ^ 32'hA5A5_0000;

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst2_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_ack(1'b1), .imem_rdata(rdata2),
    .stall(1'b0), .redirect(1'b0), .redirect_pc(32'h0),
    .id_valid(v2), .id_instr(instr2), .id_pcplus4(p42)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: fetch pointer, pending-drop flag, skid queue, ID reg.
  logic [31:0] m_pc;
  logic [31:0] m_drop_addr;
  bit          m_dropping;
  bit          m_v;
  logic [31:0] m_instr;
  logic [31:0] m_p4;
  logic [63:0] m_q[$];

  function automatic bit m_req();
    return m_q.size() == 0;
  endfunction

  function automatic logic [31:0] m_addr();
    return m_dropping ? m_drop_addr : m_pc;
  endfunction

  task automatic m_reset();
    m_pc = 32'h0;
    m_drop_addr = 32'h0;
    m_dropping = 0;
    m_v = 0;
    m_instr = 32'h0;
    m_p4 = 32'h0;
    m_q.delete();
  endtask

  task automatic m_step(input bit a, input bit s, input bit r,
                        input logic [31:0] rp, input logic [31:0] rd);
    bit req;
    bit ak;
    logic [63:0] e;
    req = m_req();
    ak = a && req;
    if (r) begin
      if (req && !ak && !m_dropping) m_drop_addr = m_pc;
      m_dropping = req && !ak;
      m_pc = rp & 32'hFFFF_FFFC;
      m_v = 0;
      m_q.delete();
    end else if (m_dropping) begin
      if (ak) m_dropping = 0;
    end else if (m_q.size() != 0) begin
      if (!s) begin
        e = m_q.pop_front();
        m_instr = e[63:32];
        m_p4 = e[31:0];
        m_v = 1;
      end
    end else if (ak) begin
      if (!m_v || !s) begin
        m_instr = rd;
        m_p4 = m_pc + 32'd4;
        m_v = 1;
      end else begin
        m_q.push_back({rd, m_pc + 32'd4});
      end
      m_pc = m_pc + 32'd4;
    end else if (!s) begin
      m_v = 0;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic cycle(input bit a, input bit s, input bit r,
                       input logic [31:0] rp, input logic [31:0] rd);
    imem_ack = a;
    stall = s;
    redirect = r;
    redirect_pc = rp;
    imem_rdata = rd;
    #1;
    chk("imem_req", {31'b0, imem_req}, {31'b0, m_req()});
    if (m_req()) chk("imem_addr", imem_addr, m_addr());
    @(posedge clk);
    m_step(a, s, r, rp, rd);
    #1;
    chk("id_valid", {31'b0, id_valid}, {31'b0, m_v});
    if (m_v) begin
      chk("id_instr", id_instr, m_instr);
      chk("id_pcplus4", id_pcplus4, m_p4);
    end
  endtask

  task automatic dcycle(input bit a, input bit s, input bit r,
                        input logic [31:0] rp);
    cycle(a, s, r, rp, m_addr() ^ 32'hA5A5_0000);
  endtask

  initial begin
    bit last_r;
    bit r;
    rst_n = 1'b0;
    rst2_n = 1'b0;
    imem_ack = 1'b0;
    imem_rdata = 32'h0;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    m_reset();
    #2;
    chk("rst_valid", {31'b0, id_valid}, 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_pcplus4", id_pcplus4, 32'h0);
    chk("rst_req", {31'b0, imem_req}, 32'h1);
    chk("rst_addr", imem_addr, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // streaming, ack always high
    for (int i = 1; i <= 2; i++) begin
      dcycle(1, 0, 0, 0);
      chk("stream_p4", id_pcplus4, 32'(4 * i));
      chk("stream_instr", id_instr, 32'(4 * (i - 1)) ^ 32'hA5A5_0000);
    end

    // ack at pc=8 while stalled -> hold
    dcycle(1, 1, 0, 0);
    chk("hold_req", {31'b0, imem_req}, 32'h0);
    chk("hold_p4", id_pcplus4, 32'd8);
    dcycle(0, 0, 0, 0);
    chk("unhold_p4", id_pcplus4, 32'd12);
    chk("unhold_addr", imem_addr, 32'd12);

    // redirect to 0x43 with the fetch at 16 outstanding
    dcycle(1, 0, 0, 0);
    chk("pre_redir_addr", imem_addr, 32'd16);
    dcycle(0, 0, 1, 32'h43);
    for (int i = 0; i < 2; i++) begin
      chk("drop_addr", imem_addr, 32'd16);
      dcycle(0, 0, 0, 0);
      chk("drop_valid", {31'b0, id_valid}, 32'h0);
    end
    dcycle(1, 0, 0, 0);
    chk("after_drop_addr", imem_addr, 32'h40);
    chk("after_drop_valid", {31'b0, id_valid}, 32'h0);

    // ack and redirect together
    dcycle(1, 0, 1, 32'h100);
    chk("ackredir_valid", {31'b0, id_valid}, 32'h0);
    chk("ackredir_addr", imem_addr, 32'h100);

    // async reset between edges while in DROP
    dcycle(0, 0, 1, 32'h200);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, id_valid}, 32'h0);
    chk("arst_addr", imem_addr, 32'h0);
    chk("arst_req", {31'b0, imem_req}, 32'h1);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;
    dcycle(1, 0, 0, 0);
    chk("arst_restart_p4", id_pcplus4, 32'd4);

    // random traffic
    last_r = 0;
    for (int i = 0; i < 3000; i++) begin
      r = !last_r && ($urandom_range(0, 7) == 0);
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, r,
            $urandom, $urandom);
      last_r = r;
    end

    // PC wrap from 0xFFFF_FFFC
    @(negedge clk);
    rst2_n = 1'b1;
    #1;
    chk("wrap_first_addr", addr2, 32'hFFFF_FFFC);
    @(posedge clk);
    #1;
    chk("wrap_valid", {31'b0, v2}, 32'h1);
    chk("wrap_p4", p42, 32'h0);
    chk("wrap_instr", instr2, 32'h5A5A_FFFC);
    chk("wrap_addr", addr2, 32'h0);
    chk("wrap_req", {31'b0, req2}, 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
